// File: rtl/srl_pkg.sv
// Shared limits and helpers for the addressable shift register.
package srl_pkg;

  localparam int unsigned WIDTH_MAX = 64;
  localparam int unsigned DEPTH_MAX = 256;

  // Ceiling log2; used to size the tap address from the stage count.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/srl_fill_ctr.sv
// Fill counter for addressable_srl: counts shifts since reset/clear, saturating at DEPTH.
module srl_fill_ctr
  import srl_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned FW    = clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          e,
  output logic [FW-1:0] fill
);

  localparam logic [FW-1:0] FillMax = FW'(DEPTH);

  logic [FW-1:0] fill_q, fill_d;

  // Clear wins over increment; a shift in the clearing cycle still counts as one word.
  always_comb begin
    fill_d = fill_q;
    if (clr) begin
      fill_d = e ? FW'(1) : '0;
    end else if (e && (fill_q != FillMax)) begin
      fill_d = fill_q + FW'(1);
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign fill = fill_q;

endmodule

// File: rtl/addressable_srl.sv
// Addressable shift register: DEPTH stages of WIDTH bits with a random-access tap.
// Optional macro ADDRESSABLE_SRL_OUTREG_EN registers z/z_valid (1-cycle latency).
module addressable_srl
  import srl_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             e,
  input  logic [WIDTH-1:0] a,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] z,
  output logic             z_valid,
  output logic [AW:0]      fill
);

  localparam logic [AW-1:0] AddrMax = AW'(DEPTH - 1);

  // No reset or clear on the data chain so it can map onto SRL primitives.
  logic [WIDTH-1:0] stage_q [DEPTH];

  logic [AW-1:0]    addr_c;
  logic [WIDTH-1:0] z_c;
  logic             z_valid_c;

  srl_fill_ctr #(
    .DEPTH (DEPTH),
    .FW    (AW + 1)
  ) u_fill_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .e     (e),
    .fill  (fill)
  );

  // Shift chain: stage 0 takes the new word, every stage moves one older.
  always_ff @(posedge clk) begin
    if (e) begin
      stage_q[0] <= a;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // Tap mux; out-of-range addresses (non-power-of-two DEPTH) read the oldest stage.
  always_comb begin
    addr_c    = (32'(addr) > DEPTH - 1) ? AddrMax : addr;
    z_c       = stage_q[addr_c];
    z_valid_c = (fill > {1'b0, addr_c});
  end

`ifdef ADDRESSABLE_SRL_OUTREG_EN
  logic [WIDTH-1:0] z_q;
  logic             z_valid_q;

  // Output registers load every cycle regardless of e.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q       <= '0;
      z_valid_q <= 1'b0;
    end else begin
      z_q       <= z_c;
      z_valid_q <= z_valid_c;
    end
  end

  assign z       = z_q;
  assign z_valid = z_valid_q;
`else
  assign z       = z_c;
  assign z_valid = z_valid_c;
`endif

endmodule

// File: tb/tb_addressable_srl.sv
// Self-checking bench for addressable_srl: DEPTH=32 main instance, DEPTH=20 clamp instance.
`timescale 1ns/100ps
module tb_addressable_srl;

  localparam int D1 = 32;
  localparam int D2 = 20;

  logic       clk = 1'b0;
  logic       rst_n, clr, e;
  logic [7:0] a;
  logic [4:0] addr, addr2;
  logic [7:0] z, z2;
  logic       zv, zv2;
  logic [5:0] fill, fill2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: history of every word shifted (newest first) and a count of
  // words shifted since the last reset/clear.
  logic [7:0] hist [$];
  int         mcount = 0;

  always #5 clk = ~clk;

  addressable_srl #(.WIDTH(8), .DEPTH(D1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .e(e), .a(a),
    .addr(addr), .z(z), .z_valid(zv), .fill(fill)
  );

  addressable_srl #(.WIDTH(8), .DEPTH(D2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .e(e), .a(a),
    .addr(addr2), .z(z2), .z_valid(zv2), .fill(fill2)
  );

  function automatic int exp_fill(input int d);
    return (mcount < d) ? mcount : d;
  endfunction

  function automatic int clamp_addr(input int d, input int ad);
    return (ad >= d) ? d - 1 : ad;
  endfunction

  function automatic bit exp_valid(input int d, input int ad);
    return exp_fill(d) > clamp_addr(d, ad);
  endfunction

  function automatic logic [7:0] exp_z(input int d, input int ad);
    return hist[clamp_addr(d, ad)];
  endfunction

  // One clock edge; the model applies the shift/clear rules to the inputs at that edge.
  task automatic tick();
    @(posedge clk);
    if (e) begin
      hist.push_front(a);
      if (hist.size() > D1) void'(hist.pop_back());
    end
    if (!rst_n) mcount = 0;
    else if (clr) mcount = e ? 1 : 0;
    else if (e && mcount < D1) mcount++;
    #1;
  endtask

  task automatic step(input logic en, input logic [7:0] d, input logic c);
    e   = en;
    a   = d;
    clr = c;
    tick();
    e   = 1'b0;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; e = 1'b0; a = '0; addr = '0; addr2 = '0;
    #2;
    n_checks++;
    if (fill !== 6'd0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", fill); end
    n_checks++;
    if (zv !== 1'b0) begin n_fail++; $display("FAIL reset_zv: got %b want 0", zv); end
    n_checks++;
    if (fill2 !== 6'd0) begin n_fail++; $display("FAIL reset_fill2: got %0d want 0", fill2); end
    n_checks++;
    if (zv2 !== 1'b0) begin n_fail++; $display("FAIL reset_zv2: got %b want 0", zv2); end
`ifdef ADDRESSABLE_SRL_OUTREG_EN
    n_checks++;
    if (z2 !== 8'h00) begin n_fail++; $display("FAIL reset_z2: got %h want 00", z2); end
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_saturate();
    for (int i = 1; i <= 40; i++) step(1'b1, 8'(i), 1'b0);
    addr = 5'd0; #1;
    n_checks++;
    if (fill !== 6'd32) begin n_fail++; $display("FAIL sat_fill: got %0d want 32", fill); end
    n_checks++;
    if (fill2 !== 6'd20) begin n_fail++; $display("FAIL sat_fill2: got %0d want 20", fill2); end
    n_checks++;
    if (zv !== 1'b1 || z !== 8'd40) begin
      n_fail++; $display("FAIL sat_addr0: got z=%0d v=%b want z=40 v=1", z, zv);
    end
    addr = 5'd31; #1;
    n_checks++;
    if (zv !== 1'b1 || z !== 8'd9) begin
      n_fail++; $display("FAIL sat_addr31: got z=%0d v=%b want z=9 v=1", z, zv);
    end
  endtask

  task automatic test_partial();
    step(1'b0, 8'h00, 1'b1);
    for (int i = 1; i <= 5; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
    n_checks++;
    if (fill !== 6'd5) begin n_fail++; $display("FAIL part_fill: got %0d want 5", fill); end
    addr = 5'd4; #1;
    n_checks++;
    if (zv !== 1'b1 || z !== 8'hA1) begin
      n_fail++; $display("FAIL part_addr4: got z=%h v=%b want z=a1 v=1", z, zv);
    end
    addr = 5'd5; #1;
    n_checks++;
    if (zv !== 1'b0) begin n_fail++; $display("FAIL part_addr5: got v=%b want 0", zv); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 96; c++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 15) == 0));
      for (int ph = 0; ph < 2; ph++) begin
        if (ph == 1) begin
          @(negedge clk);
          #0.1;
        end
        n_checks++;
        if (fill !== 6'(exp_fill(D1))) begin
          n_fail++; $display("FAIL rnd_fill c=%0d: got %0d want %0d", c, fill, exp_fill(D1));
        end
        for (int t = 0; t < D1; t++) begin
          addr  = 5'(t);
          addr2 = 5'($urandom_range(0, 31));
          #0.1;
          n_checks++;
          if (zv !== exp_valid(D1, t)) begin
            n_fail++; $display("FAIL rnd_zv c=%0d t=%0d: got %b want %b", c, t, zv, exp_valid(D1, t));
          end else if (exp_valid(D1, t) && z !== exp_z(D1, t)) begin
            n_fail++; $display("FAIL rnd_z c=%0d t=%0d: got %h want %h", c, t, z, exp_z(D1, t));
          end
          n_checks++;
          if (zv2 !== exp_valid(D2, int'(addr2))) begin
            n_fail++;
            $display("FAIL rnd_zv2 c=%0d a2=%0d: got %b want %b", c, addr2, zv2,
                     exp_valid(D2, int'(addr2)));
          end else if (exp_valid(D2, int'(addr2)) && z2 !== exp_z(D2, int'(addr2))) begin
            n_fail++;
            $display("FAIL rnd_z2 c=%0d a2=%0d: got %h want %h", c, addr2, z2,
                     exp_z(D2, int'(addr2)));
          end
        end
      end
    end
  endtask

  task automatic test_clr_shift();
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b0);
    n_checks++;
    if (fill !== 6'd20) begin n_fail++; $display("FAIL clr_pre_fill: got %0d want 20", fill); end
    step(1'b1, 8'h5C, 1'b1);
    n_checks++;
    if (fill !== 6'd1) begin n_fail++; $display("FAIL clr_fill: got %0d want 1", fill); end
    addr = 5'd0; #1;
    n_checks++;
    if (zv !== 1'b1 || z !== 8'h5C) begin
      n_fail++; $display("FAIL clr_addr0: got z=%h v=%b want z=5c v=1", z, zv);
    end
    addr = 5'd1; #1;
    n_checks++;
    if (zv !== 1'b0) begin n_fail++; $display("FAIL clr_addr1: got v=%b want 0", zv); end
  endtask

  task automatic test_reset_midstream();
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom), 1'b0);
    n_checks++;
    if (fill !== 6'd12) begin n_fail++; $display("FAIL mid_pre_fill: got %0d want 12", fill); end
    addr = 5'd0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    mcount = 0;
    #1;
    n_checks++;
    if (fill !== 6'd0 || zv !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst: got fill=%0d v=%b want fill=0 v=0", fill, zv);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (fill !== 6'd0 || zv !== 1'b0) begin
      n_fail++; $display("FAIL mid_release: got fill=%0d v=%b want fill=0 v=0", fill, zv);
    end
    step(1'b1, 8'h3C, 1'b0);
    n_checks++;
    if (fill !== 6'd1 || zv !== 1'b1 || z !== 8'h3C) begin
      n_fail++;
      $display("FAIL mid_first: got fill=%0d z=%h v=%b want fill=1 z=3c v=1", fill, z, zv);
    end
  endtask

  task automatic test_clamp();
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 25; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
    addr2 = 5'd31; #1;
    n_checks++;
    if (zv2 !== 1'b1 || z2 !== 8'h65) begin
      n_fail++; $display("FAIL clamp_31: got z=%h v=%b want z=65 v=1", z2, zv2);
    end
    addr2 = 5'd19; #1;
    n_checks++;
    if (zv2 !== 1'b1 || z2 !== 8'h65) begin
      n_fail++; $display("FAIL clamp_19: got z=%h v=%b want z=65 v=1", z2, zv2);
    end
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
    addr2 = 5'd25; #1;
    n_checks++;
    if (zv2 !== 1'b0) begin n_fail++; $display("FAIL clamp_25_short: got v=%b want 0", zv2); end
    addr2 = 5'd4; #1;
    n_checks++;
    if (zv2 !== 1'b1) begin n_fail++; $display("FAIL clamp_4_short: got v=%b want 1", zv2); end
  endtask

`ifdef ADDRESSABLE_SRL_OUTREG_EN
  task automatic test_outreg();
    addr2 = 5'd0;
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 25; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
    // Output holds the tap as it was just before the last shift.
    n_checks++;
    if (zv2 !== 1'b1 || z2 !== 8'h77) begin
      n_fail++; $display("FAIL oreg_shift_lag: got z=%h v=%b want z=77 v=1", z2, zv2);
    end
    step(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (z2 !== 8'h78) begin n_fail++; $display("FAIL oreg_shift: got %h want 78", z2); end
    addr2 = 5'd31; #1;
    n_checks++;
    if (z2 !== 8'h78) begin n_fail++; $display("FAIL oreg_addr_lag: got %h want 78", z2); end
    step(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (zv2 !== 1'b1 || z2 !== 8'h65) begin
      n_fail++; $display("FAIL oreg_clamp: got z=%h v=%b want z=65 v=1", z2, zv2);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (z2 !== 8'h00 || zv2 !== 1'b0 || fill2 !== 6'd0) begin
      n_fail++;
      $display("FAIL oreg_rst: got z=%h v=%b fill=%0d want 00 0 0", z2, zv2, fill2);
    end
    tick();
    rst_n = 1'b1;
    addr2 = 5'd0;
    step(1'b1, 8'h11, 1'b0);
    n_checks++;
    if (zv2 !== 1'b0 || fill2 !== 6'd1) begin
      n_fail++; $display("FAIL oreg_v_lag: got v=%b fill=%0d want v=0 fill=1", zv2, fill2);
    end
    step(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (zv2 !== 1'b1 || z2 !== 8'h11) begin
      n_fail++; $display("FAIL oreg_v: got z=%h v=%b want z=11 v=1", z2, zv2);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef ADDRESSABLE_SRL_OUTREG_EN
    test_outreg();
`else
    test_saturate();
    test_partial();
    test_random();
    test_clr_shift();
    test_reset_midstream();
    test_clamp();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addressable_srl.md
ADDRESSABLE_SRL -- requirements
Module: addressable_srl

Interface
- REQ-001: Parameter WIDTH, default 8: data bits per stage; legal range 1..64.
- REQ-002: Parameter DEPTH, default 32: number of shift stages; legal range 2..256.
- REQ-003: Derived constant AW = clog2(DEPTH): tap address width.
- REQ-004: Port clk, input, 1: single clock; all state updates on its rising edge.
- REQ-005: Port rst_n, input, 1: reset, asynchronous, active-low.
- REQ-006: Port clr, input, 1: synchronous clear of the fill count.
- REQ-007: Port e, input, 1: shift enable.
- REQ-008: Port a, input, WIDTH: data shifted into stage 0.
- REQ-009: Port addr, input, AW: tap select; 0 selects the newest stage, DEPTH-1 the oldest.
- REQ-010: Port z, output, WIDTH: data at the selected tap.
- REQ-011: Port z_valid, output, 1: selected tap holds data written since the last reset or clear.
- REQ-012: Port fill, output, AW+1: number of valid stages, 0..DEPTH.

Function
- REQ-013: When e=1 at a clock edge: stage[0] <= a and stage[i] <= stage[i-1] for i=1..DEPTH-1; when e=0 all stages hold.
- REQ-014: Data stages have no reset and no clear, so the chain stays mappable to SRL primitives.
- REQ-015: fill increments by 1 on each edge with e=1 and saturates at DEPTH.
- REQ-016: clr=1, e=0 at an edge: fill <= 0.
- REQ-017: clr=1, e=1 at an edge: data shifts per REQ-013 and fill <= 1 (clr takes priority over the increment, then the new word counts).
- REQ-018: z_valid = (fill > addr).
- REQ-019: addr values >= DEPTH (non-power-of-two DEPTH) are clamped to DEPTH-1 for both z and z_valid.
- REQ-020: z is don't-care whenever z_valid=0; checkers compare z only when z_valid=1.
- REQ-021: Without the option in REQ-025, z and z_valid are combinational from addr and the current stage/fill state, with zero latency.
- REQ-022: A change of addr while e=0 re-reads a different stage without disturbing any state.

Reset
- REQ-023: rst_n=0 asynchronously forces fill=0 and z_valid=0; data stages keep their values per REQ-014.
- REQ-024: Reset asserted mid-stream discards all validity; after release, validity rebuilds only from new shifts.

Configuration
- REQ-025: Macro ADDRESSABLE_SRL_OUTREG_EN defined: z and z_valid are registered every clock, not gated by e, giving 1-cycle latency from addr or a shift to the output; both output registers reset to 0 on rst_n=0.
- REQ-026: Macro ADDRESSABLE_SRL_OUTREG_EN undefined: REQ-021 applies, and no output flops exist.

Structure
- REQ-027: Package srl_pkg holds WIDTH_MAX=64, DEPTH_MAX=256, and the clog2 function used for AW.
- REQ-028: Sub-module srl_fill_ctr implements fill (increment, saturate, clr, rst_n); the shift chain and tap mux live in addressable_srl.

Verification
- REQ-029: WIDTH=8, DEPTH=32; reset, then shift a=1..40 with e=1 -> fill saturates at 32, addr=0 gives z=40, addr=31 gives z=9, z_valid=1 at both.
- REQ-030: After 5 shifts of 0xA1..0xA5 -> addr=4 gives z=0xA1 with z_valid=1; addr=5 gives z_valid=0.
- REQ-031: e toggled randomly for 96 cycles -> z matches a behavioural reference model at every tap whenever z_valid=1, sampled on both clock edges.
- REQ-032: clr=1 with e=1 while fill=20, a=0x5C -> fill=1 next cycle, addr=0 gives z=0x5C with z_valid=1, addr=1 gives z_valid=0.
- REQ-033: rst_n pulsed low between clock edges while fill=12 -> fill=0 and z_valid=0 immediately; after release, first shift gives fill=1.
- REQ-034: DEPTH=20 with ADDRESSABLE_SRL_OUTREG_EN defined, addr=31 -> clamped to stage 19; z and z_valid lag the combinational build by exactly 1 cycle, and both are 0 during reset.
